// File: rtl/bram_pkg.sv
// Shared types, helpers and parameter check for the bram_*_wrapper family.
`ifndef BRAM_PKG_SV
`define BRAM_PKG_SV

// Elaboration-time guard: the address must cover DEPTH and the lanes must tile the word.
`define BRAM_PARAM_CHECK(DEPTH_P, AW_P, DW_P, BMW_P) \
  if (((2 ** (AW_P)) < (DEPTH_P)) || (((DW_P) % (BMW_P)) != 0)) begin : g_param_err \
    $error("bram wrapper: illegal DEPTH/ADDR_WIDTH/DATA_WIDTH/BITMASK_WIDTH"); \
  end

package bram_pkg;

  typedef enum logic {
    ST_INIT,
    ST_READY
  } bram_init_state_t;

  function automatic int lane_width(input int dw, input int bmw);
    return dw / bmw;
  endfunction

endpackage

`endif

// File: rtl/bram_1rw_init_wrapper_if.sv
// Client-side access bus of the single-port BRAM wrapper.
interface bram_1rw_init_wrapper_if #(
  parameter int AW  = 6,
  parameter int DW  = 32,
  parameter int BMW = 4
);
  logic           CE;
  logic [AW-1:0]  A;
  logic           RDWEN;
  logic [BMW-1:0] BW;
  logic [DW-1:0]  DIN;
  logic [DW-1:0]  DOUT;
  logic           DVALID;
  logic           BUSY;
  logic           ADDR_ERR;

  modport master (
    output CE, A, RDWEN, BW, DIN,
    input  DOUT, DVALID, BUSY, ADDR_ERR
  );

  modport slave (
    input  CE, A, RDWEN, BW, DIN,
    output DOUT, DVALID, BUSY, ADDR_ERR
  );
endinterface

// File: rtl/bram_init_seq.sv
// Sequential zero-init engine: walks every address once after reset.
module bram_init_seq
  import bram_pkg::*;
#(
  parameter int DEPTH = 64,
  parameter int AW    = 6
) (
  input  logic          clk_i,
  input  logic          rst_i,
  output logic          init_we_o,
  output logic [AW-1:0] init_addr_o,
  output logic          busy_o
);

  // One extra bit so DEPTH == 2**AW reaches its last address without wrapping.
  localparam logic [AW:0] LAST = (AW+1)'(DEPTH - 1);

  bram_init_state_t state_q;
  logic [AW:0]      cnt_q;
  logic             busy_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= ST_INIT;
      cnt_q   <= '0;
      busy_q  <= 1'b1;
    end else begin
      unique case (state_q)
        ST_INIT: begin
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == LAST) begin
            state_q <= ST_READY;
            busy_q  <= 1'b0;
          end
        end
        ST_READY: ;
        default: ;
      endcase
    end
  end

  assign init_we_o   = busy_q;
  assign init_addr_o = cnt_q[AW-1:0];
  assign busy_o      = busy_q;

endmodule

// File: rtl/bram_1rw_init_wrapper.sv
// Single-port BRAM wrapper: lane-masked writes, init engine, 1/2-stage read pipe.
module bram_1rw_init_wrapper
  import bram_pkg::*;
#(
  parameter int DEPTH         = 64,
  parameter int ADDR_WIDTH    = 6,
  parameter int DATA_WIDTH    = 32,
  parameter int BITMASK_WIDTH = 4,
  parameter bit OUT_REG       = 1'b0,
  parameter bit HOLD_DOUT     = 1'b0,
  parameter logic [DATA_WIDTH-1:0] INIT_VALUE = '0
) (
  input logic MEMCLK,
  input logic RESET,
  bram_1rw_init_wrapper_if.slave bus
);

  localparam int L = lane_width(DATA_WIDTH, BITMASK_WIDTH);
  localparam logic [ADDR_WIDTH:0] DEPTH_C = (ADDR_WIDTH+1)'(DEPTH);

  `BRAM_PARAM_CHECK(DEPTH, ADDR_WIDTH, DATA_WIDTH, BITMASK_WIDTH)

  logic                  init_we;
  logic                  busy;
  logic [ADDR_WIDTH-1:0] init_addr;

  bram_init_seq #(
    .DEPTH (DEPTH),
    .AW    (ADDR_WIDTH)
  ) u_init (
    .clk_i       (MEMCLK),
    .rst_i       (RESET),
    .init_we_o   (init_we),
    .init_addr_o (init_addr),
    .busy_o      (busy)
  );

  logic in_rng;
  logic acc;
  logic wr_en;
  logic rd_en;

  assign in_rng = ({1'b0, bus.A} < DEPTH_C);
  assign acc    = bus.CE & ~busy;
  assign wr_en  = acc & ~bus.RDWEN & in_rng;
  assign rd_en  = acc & bus.RDWEN;

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [DATA_WIDTH-1:0] rdata_q;

  // Array and read register stay reset-free so the macro infers cleanly.
  always_ff @(posedge MEMCLK) begin
    if (init_we) begin
      mem[init_addr] <= INIT_VALUE;
    end else if (wr_en) begin
      for (int i = 0; i < BITMASK_WIDTH; i++) begin
        if (bus.BW[i]) mem[bus.A][i*L +: L] <= bus.DIN[i*L +: L];
      end
    end
    if (rd_en && in_rng) rdata_q <= mem[bus.A];
  end

  logic                  v1_q;
  logic                  oob1_q;
  logic                  err_q;
  logic [DATA_WIDTH-1:0] d1;
  logic                  vld;
  logic [DATA_WIDTH-1:0] dat;
  logic [DATA_WIDTH-1:0] hold_q;

  assign d1 = oob1_q ? INIT_VALUE : rdata_q;

  always_ff @(posedge MEMCLK or posedge RESET) begin
    if (RESET) begin
      v1_q   <= 1'b0;
      oob1_q <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      v1_q   <= rd_en;
      oob1_q <= rd_en & ~in_rng;
      if (acc && !in_rng) err_q <= 1'b1;
    end
  end

  if (OUT_REG) begin : g_oreg
    logic                  v2_q;
    logic [DATA_WIDTH-1:0] d2_q;
    always_ff @(posedge MEMCLK or posedge RESET) begin
      if (RESET) begin
        v2_q <= 1'b0;
        d2_q <= '0;
      end else begin
        v2_q <= v1_q;
        if (v1_q) d2_q <= d1;
      end
    end
    assign vld = v2_q;
    assign dat = d2_q;
  end else begin : g_noreg
    assign vld = v1_q;
    assign dat = d1;
  end

  always_ff @(posedge MEMCLK or posedge RESET) begin
    if (RESET) hold_q <= '0;
    else if (vld) hold_q <= dat;
  end

  assign bus.DOUT     = vld ? dat : (HOLD_DOUT ? hold_q : '0);
  assign bus.DVALID   = vld;
  assign bus.BUSY     = busy;
  assign bus.ADDR_ERR = err_q;

endmodule
